regfile_wr_arbiter: RTL and testbench

Owns the single write port of the register file and shares it between two writeback requesters: A (ALU writeback) and B (load writeback).
After reset, or on command, it first sweeps every register to a clear value, then arbitrates round-robin.
It drives WADDR/DIN/WE of the register file from registered outputs.
The read ports are untouched by this block.

---
 rtl/regfile_wr_arbiter_pkg.sv | 16 +
 rtl/regfile_wr_arbiter_rr_arb2.sv | 46 ++++
 rtl/regfile_wr_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   state_e  : sequencer states (CLEAR sweep, RUN arbitration)
//   req_id_e : requester identity, used for the round-robin LAST pointer
package regfile_wr_arbiter_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-input round-robin grant with a LAST pointer.
//   CLK    : clock
//   RESET  : synchronous active-high reset; LAST returns to B so A wins the first tie
//   en     : grant enable; no grant and no LAST update while low
//   a_req  : requester A pending
//   b_req  : requester B pending
//   a_gnt  : combinational grant to A
//   b_gnt  : combinational grant to B
module rr_arb2
  import regfile_wr_arbiter_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  req_id_e last;

  // On a tie the requester not named by LAST wins.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (en) begin
      if (a_req && (!b_req || last == REQ_B)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last <= REQ_B;
    end else if (a_gnt) begin
      last <= REQ_A;
    end else if (b_gnt) begin
      last <= REQ_B;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owner of the register file write port. After reset or a CLR pulse it sweeps
// every register to CLRVAL, then shares the port round-robin between the ALU
// writeback (A) and the load writeback (B).
//   CLK, RESET           : clock, synchronous active-high reset
//   CLR                  : one-cycle pulse in RUN restarting the clear sweep
//   A_REQ/A_ADDR/A_DATA  : requester A write; A_GNT combinational accept
//   B_REQ/B_ADDR/B_DATA  : requester B write; B_GNT combinational accept
//   WE/WADDR/DIN         : registered register-file write port (one cycle after grant)
//   BUSY                 : high while the sequencer is in CLEAR
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int                DBITS  = 32,
  parameter int                ABITS  = 4,
  parameter int                WORDS  = 1 << ABITS,
  parameter logic [DBITS-1:0]  CLRVAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLR,
  input  logic             A_REQ,
  input  logic [ABITS-1:0] A_ADDR,
  input  logic [DBITS-1:0] A_DATA,
  output logic             A_GNT,
  input  logic             B_REQ,
  input  logic [ABITS-1:0] B_ADDR,
  input  logic [DBITS-1:0] B_DATA,
  output logic             B_GNT,
  output logic             WE,
  output logic [ABITS-1:0] WADDR,
  output logic [DBITS-1:0] DIN,
  output logic             BUSY
);

  localparam logic [ABITS:0] CNT_LAST = (ABITS+1)'(WORDS - 1);

  state_e         state;
  state_e         state_nxt;
  logic [ABITS:0] cnt;
  logic [ABITS:0] cnt_nxt;
  logic           arb_en;

  // A CLR pulse suppresses grants in the same cycle so no write is lost to the sweep.
  assign arb_en = (state == ST_RUN) && !CLR;
  assign BUSY   = (state == ST_CLEAR);

  rr_arb2 u_arb (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (arb_en),
    .a_req (A_REQ),
    .b_req (B_REQ),
    .a_gnt (A_GNT),
    .b_gnt (B_GNT)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // CLR is only honoured in RUN; a pulse during the sweep is ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (CLR) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Write port registers: grant in cycle N -> write presented in cycle N+1.
  // Without a grant WADDR/DIN keep their last values; only WE drops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      WE    <= 1'b0;
      WADDR <= '0;
      DIN   <= '0;
    end else if (state == ST_CLEAR) begin
      WE    <= 1'b1;
      WADDR <= cnt[ABITS-1:0];
      DIN   <= CLRVAL;
    end else if (A_GNT) begin
      WE    <= 1'b1;
      WADDR <= A_ADDR;
      DIN   <= A_DATA;
    end else if (B_GNT) begin
      WE    <= 1'b1;
      WADDR <= B_ADDR;
      DIN   <= B_DATA;
    end else begin
      WE    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic        CLK = 1'b0;
  logic        RESET, CLR;
  logic        A_REQ, B_REQ;
  logic [3:0]  A_ADDR, B_ADDR;
  logic [31:0] A_DATA, B_DATA;
  logic        A_GNT, B_GNT, WE, BUSY;
  logic [3:0]  WADDR;
  logic [31:0] DIN;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: clearing flag, sweep index, who was served last,
  // expected write-port contents and expected register file contents.
  bit          m_clr    = 1'b1;
  int          m_idx    = 0;
  bit          m_last_b = 1'b1;
  logic        m_we     = 1'b0;
  logic [3:0]  m_waddr  = '0;
  logic [31:0] m_din    = '0;
  logic [31:0] m_rf [16];

  // Register file stand-in driven by the DUT's write port.
  logic [31:0] rf [16];

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (WE === 1'b1) rf[WADDR] <= DIN;
  end

  regfile_wr_arbiter #(.DBITS(32), .ABITS(4)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .CLR    (CLR),
    .A_REQ  (A_REQ),
    .A_ADDR (A_ADDR),
    .A_DATA (A_DATA),
    .A_GNT  (A_GNT),
    .B_REQ  (B_REQ),
    .B_ADDR (B_ADDR),
    .B_DATA (B_DATA),
    .B_GNT  (B_GNT),
    .WE     (WE),
    .WADDR  (WADDR),
    .DIN    (DIN),
    .BUSY   (BUSY)
  );

  // Who should be granted this cycle, from the current inputs and model state.
  function automatic void exp_gnt(output bit ga, output bit gb);
    ga = 1'b0;
    gb = 1'b0;
    if (!m_clr && !CLR) begin
      if (A_REQ && B_REQ) begin
        if (m_last_b) ga = 1'b1;
        else          gb = 1'b1;
      end else if (A_REQ) begin
        ga = 1'b1;
      end else if (B_REQ) begin
        gb = 1'b1;
      end
    end
  endfunction

  // Advance one clock; the model takes the same step from the same inputs.
  task automatic tick();
    bit ga, gb;
    exp_gnt(ga, gb);
    if (m_we) m_rf[m_waddr] = m_din;
    if (RESET) begin
      m_clr = 1'b1; m_idx = 0; m_last_b = 1'b1;
      m_we = 1'b0; m_waddr = '0; m_din = '0;
    end else if (m_clr) begin
      m_we = 1'b1; m_waddr = 4'(m_idx); m_din = '0;
      if (m_idx == 15) m_clr = 1'b0;
      m_idx++;
    end else if (CLR) begin
      m_we = 1'b0; m_clr = 1'b1; m_idx = 0;
    end else if (ga) begin
      m_we = 1'b1; m_waddr = A_ADDR; m_din = A_DATA; m_last_b = 1'b0;
    end else if (gb) begin
      m_we = 1'b1; m_waddr = B_ADDR; m_din = B_DATA; m_last_b = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; CLR = 1'b0;
    A_REQ = 1'b0; A_ADDR = '0; A_DATA = '0;
    B_REQ = 1'b0; B_ADDR = '0; B_DATA = '0;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_err++; $display("FAIL reset_busy got %b want 1", BUSY);
    end
    n_checks++;
    if ({WE, WADDR, DIN} !== {1'b0, 4'h0, 32'h0}) begin
      n_err++; $display("FAIL reset_port got we=%b waddr=%h din=%h want 0/0/0", WE, WADDR, DIN);
    end
  endtask

  task automatic test_clear_sweep();
    int waq[$];
    int gcyc = -1;
    bit ga, gb, ok;
    RESET = 1'b1;
    A_REQ = 1'b1; A_ADDR = 4'd9; A_DATA = $urandom;
    tick();
    RESET = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      exp_gnt(ga, gb);
      n_checks++;
      if ({A_GNT, B_GNT, BUSY, WE, WADDR, DIN} !== {ga, gb, m_clr, m_we, m_waddr, m_din}) begin
        n_err++;
        $display("FAIL sweep c%0d got gnt=%b%b busy=%b we=%b %h %h want %b%b %b %b %h %h",
                 c, A_GNT, B_GNT, BUSY, WE, WADDR, DIN, ga, gb, m_clr, m_we, m_waddr, m_din);
      end
      if (c < 17 && WE === 1'b1) waq.push_back(int'(WADDR));
      if (A_GNT === 1'b1 && gcyc < 0) gcyc = c;
      tick();
      if (ga) A_REQ = 1'b0;
    end
    ok = (waq.size() == 16);
    foreach (waq[i]) if (waq[i] != i) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_err++; $display("FAIL sweep_addrs got %0d writes want 16 ascending 0..15", waq.size());
    end
    n_checks++;
    if (gcyc != 16) begin
      n_err++; $display("FAIL sweep_first_grant got cycle %0d want 16", gcyc);
    end
  endtask

  task automatic test_single();
    tick();
    A_REQ = 1'b1; A_ADDR = 4'd5; A_DATA = 32'hDEADBEEF;
    @(negedge CLK);
    n_checks++;
    if ({A_GNT, B_GNT} !== 2'b10) begin
      n_err++; $display("FAIL single_gnt got %b%b want 10", A_GNT, B_GNT);
    end
    tick();
    A_REQ = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({WE, WADDR, DIN} !== {1'b1, 4'd5, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL single_write got %b %h %h want 1 5 deadbeef", WE, WADDR, DIN);
    end
    tick();
    @(negedge CLK);
    n_checks++;
    if ({WE, WADDR, DIN} !== {1'b0, 4'd5, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL single_idle got %b %h %h want 0 5 deadbeef", WE, WADDR, DIN);
    end
    tick();
  endtask

  task automatic test_contention();
    int order[$];
    bit ga, gb;
    RESET = 1'b1;
    A_REQ = 1'b1; A_ADDR = 4'($urandom); A_DATA = $urandom;
    B_REQ = 1'b1; B_ADDR = 4'($urandom); B_DATA = $urandom;
    tick();
    RESET = 1'b0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge CLK);
      exp_gnt(ga, gb);
      n_checks++;
      if ({A_GNT, B_GNT, BUSY, WE, WADDR, DIN} !== {ga, gb, m_clr, m_we, m_waddr, m_din}) begin
        n_err++;
        $display("FAIL contend c%0d got gnt=%b%b busy=%b we=%b %h %h want %b%b %b %b %h %h",
                 c, A_GNT, B_GNT, BUSY, WE, WADDR, DIN, ga, gb, m_clr, m_we, m_waddr, m_din);
      end
      if (A_GNT === 1'b1) order.push_back(0);
      if (B_GNT === 1'b1) order.push_back(1);
      tick();
      if (ga) begin A_ADDR = 4'($urandom); A_DATA = $urandom; end
      if (gb) begin B_ADDR = 4'($urandom); B_DATA = $urandom; end
    end
    A_REQ = 1'b0; B_REQ = 1'b0;
    n_checks++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      n_err++; $display("FAIL contend_order got %p want A,B,A,B (0,1,0,1)", order);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({WE, WADDR, DIN} !== {m_we, m_waddr, m_din}) begin
        n_err++; $display("FAIL contend_tail c%0d got %b %h %h want %b %h %h",
                          c, WE, WADDR, DIN, m_we, m_waddr, m_din);
      end
      tick();
    end
  endtask

  task automatic test_collision();
    int order[$];
    bit ga, gb;
    A_REQ = 1'b1; A_ADDR = 4'd3; A_DATA = 32'h11;
    B_REQ = 1'b1; B_ADDR = 4'd3; B_DATA = 32'h22;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      exp_gnt(ga, gb);
      n_checks++;
      if ({A_GNT, B_GNT, WE, WADDR, DIN} !== {ga, gb, m_we, m_waddr, m_din}) begin
        n_err++;
        $display("FAIL collide c%0d got gnt=%b%b we=%b %h %h want %b%b %b %h %h",
                 c, A_GNT, B_GNT, WE, WADDR, DIN, ga, gb, m_we, m_waddr, m_din);
      end
      if (A_GNT === 1'b1) order.push_back(0);
      if (B_GNT === 1'b1) order.push_back(1);
      tick();
      if (ga) A_REQ = 1'b0;
      if (gb) B_REQ = 1'b0;
    end
    n_checks++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
      n_err++; $display("FAIL collide_order got %p want A then B (0,1)", order);
    end
    n_checks++;
    if (rf[3] !== 32'h22) begin
      n_err++; $display("FAIL collide_reg3 got %h want 00000022", rf[3]);
    end
  endtask

  task automatic test_clr();
    int wecnt = 0;
    int gc = -1;
    int fb = -1;
    bit ga, gb;
    A_REQ = 1'b1; A_ADDR = 4'd12; A_DATA = $urandom;
    CLR = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({A_GNT, B_GNT} !== 2'b00) begin
      n_err++; $display("FAIL clr_nogrant got %b%b want 00", A_GNT, B_GNT);
    end
    tick();
    CLR = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      exp_gnt(ga, gb);
      n_checks++;
      if ({A_GNT, B_GNT, BUSY, WE, WADDR, DIN} !== {ga, gb, m_clr, m_we, m_waddr, m_din}) begin
        n_err++;
        $display("FAIL clr_seq c%0d got gnt=%b%b busy=%b we=%b %h %h want %b%b %b %b %h %h",
                 c, A_GNT, B_GNT, BUSY, WE, WADDR, DIN, ga, gb, m_clr, m_we, m_waddr, m_din);
      end
      if (c <= 16 && WE === 1'b1) wecnt++;
      if (A_GNT === 1'b1 && gc < 0) gc = c;
      if (BUSY === 1'b0 && fb < 0) fb = c;
      tick();
      if (ga) A_REQ = 1'b0;
    end
    n_checks++;
    if (wecnt != 16) begin
      n_err++; $display("FAIL clr_sweep_len got %0d want 16", wecnt);
    end
    n_checks++;
    if (gc != 16 || fb != 16) begin
      n_err++; $display("FAIL clr_first_grant got grant c%0d run c%0d want 16/16", gc, fb);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int waq[$];
    bit found = 1'b0;
    bit ga, gb, ok;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge CLK);
      if (WE === 1'b1 && WADDR === 4'd7) found = 1'b1;
      else tick();
    end
    n_checks++;
    if (!found) begin
      n_err++; $display("FAIL midreset_reach got no write to 7 want write to 7");
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(negedge CLK);
      exp_gnt(ga, gb);
      if (c == 0) begin
        n_checks++;
        if ({WE, BUSY} !== 2'b01) begin
          n_err++; $display("FAIL midreset_we got we=%b busy=%b want 0/1", WE, BUSY);
        end
      end
      n_checks++;
      if ({A_GNT, B_GNT, BUSY, WE, WADDR, DIN} !== {ga, gb, m_clr, m_we, m_waddr, m_din}) begin
        n_err++;
        $display("FAIL midreset_seq c%0d got gnt=%b%b busy=%b we=%b %h %h want %b%b %b %b %h %h",
                 c, A_GNT, B_GNT, BUSY, WE, WADDR, DIN, ga, gb, m_clr, m_we, m_waddr, m_din);
      end
      if (WE === 1'b1) waq.push_back(int'(WADDR));
      tick();
    end
    ok = (waq.size() == 16);
    foreach (waq[i]) if (waq[i] != i) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_err++; $display("FAIL midreset_addrs got %0d writes want 16 ascending 0..15", waq.size());
    end
  endtask

  task automatic test_random();
    bit ga, gb;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      exp_gnt(ga, gb);
      n_checks++;
      if ({A_GNT, B_GNT, BUSY, WE, WADDR, DIN} !== {ga, gb, m_clr, m_we, m_waddr, m_din}) begin
        n_err++;
        $display("FAIL random c%0d got gnt=%b%b busy=%b we=%b %h %h want %b%b %b %b %h %h",
                 c, A_GNT, B_GNT, BUSY, WE, WADDR, DIN, ga, gb, m_clr, m_we, m_waddr, m_din);
      end
      tick();
      if (!A_REQ || ga) begin
        A_REQ = ($urandom % 3) != 0; A_ADDR = 4'($urandom); A_DATA = $urandom;
      end
      if (!B_REQ || gb) begin
        B_REQ = ($urandom % 3) != 0; B_ADDR = 4'($urandom); B_DATA = $urandom;
      end
      CLR = !m_clr && ($urandom % 60 == 0);
    end
    A_REQ = 1'b0; B_REQ = 1'b0; CLR = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rf[i] !== m_rf[i]) begin
        n_err++; $display("FAIL random_rf[%0d] got %h want %h", i, rf[i], m_rf[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    test_reset();
    test_clear_sweep();
    test_single();
    test_contention();
    test_collision();
    test_clr();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
